// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, control bundle and helpers for the load-use scoreboard.
package hazard_pkg;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int REG_ZERO = 0;
    localparam int LOAD_LAT_MAX = 8;
    typedef struct packed {
        logic PCWrite;
        logic IFIDWrite;
        logic OP;
        logic IFIDFlush;
    } hazard_ctl_t;
    localparam hazard_ctl_t CTL_RUN    = '{PCWrite: 1'b1, IFIDWrite: 1'b1, OP: 1'b1, IFIDFlush: 1'b0};
    localparam hazard_ctl_t CTL_FREEZE = '{PCWrite: 1'b0, IFIDWrite: 1'b0, OP: 1'b1, IFIDFlush: 1'b0};
    localparam hazard_ctl_t CTL_FLUSH  = '{PCWrite: 1'b1, IFIDWrite: 1'b1, OP: 1'b0, IFIDFlush: 1'b1};
    localparam hazard_ctl_t CTL_STALL  = '{PCWrite: 1'b0, IFIDWrite: 1'b0, OP: 1'b0, IFIDFlush: 1'b0};
    function automatic int cnt_width(input int lat);
        return lat > 1 ? $clog2(lat) : 1;
    endfunction
endpackage

// File: rtl/load_use_scoreboard_if.sv
// load_use_scoreboard_if: ID-stage hazard bus; StallCount present only with LOAD_USE_STALL_CNT_EN.
interface load_use_scoreboard_if #(parameter int REG_ADDR_W = hazard_pkg::DEF_REG_ADDR_W);
    logic                  IDEX_MemRead;
    logic [REG_ADDR_W-1:0] IDEX_RegisterRt;
    logic [REG_ADDR_W-1:0] IFID_RegisterRs;
    logic [REG_ADDR_W-1:0] IFID_RegisterRt;
    logic                  IFID_UsesRs;
    logic                  IFID_UsesRt;
    logic                  BranchTaken;
    logic                  MemStall;
    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  OP;
    logic                  IFIDFlush;
`ifdef LOAD_USE_STALL_CNT_EN
    logic [31:0]           StallCount;
    modport master (
        output IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
        output IFID_UsesRs, IFID_UsesRt, BranchTaken, MemStall,
        input  PCWrite, IFIDWrite, OP, IFIDFlush, StallCount
    );
    modport slave (
        input  IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
        input  IFID_UsesRs, IFID_UsesRt, BranchTaken, MemStall,
        output PCWrite, IFIDWrite, OP, IFIDFlush, StallCount
    );
`else
    modport master (
        output IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
        output IFID_UsesRs, IFID_UsesRt, BranchTaken, MemStall,
        input  PCWrite, IFIDWrite, OP, IFIDFlush
    );
    modport slave (
        input  IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
        input  IFID_UsesRs, IFID_UsesRt, BranchTaken, MemStall,
        output PCWrite, IFIDWrite, OP, IFIDFlush
    );
`endif
endinterface

// File: rtl/load_use_scoreboard_sb_entry.sv
// sb_entry: one scoreboard countdown; hold freezes it, load restarts it, otherwise it counts to zero.
module sb_entry #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic             hold,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (!hold) begin
            if (load) cnt <= load_val;
            else if (dec && cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    assign busy = cnt != '0;
endmodule

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: per-register countdown load-use detector driving PC/IFID enables, bubble and flush.
// Optional StallCount saturating counter enabled by LOAD_USE_STALL_CNT_EN.
module load_use_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = cnt_width(LOAD_LAT)
) (
    input logic                  clk,
    input logic                  rst_n,
    load_use_scoreboard_if.slave bus
);
    localparam int NREG = 1 << REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] RZ = REG_ADDR_W'(REG_ZERO);
    logic [NREG-1:0] busy;
    logic            capture, m_rs, m_rt, hazard;
    hazard_ctl_t     ctl;
    assign capture = !bus.MemStall && bus.IDEX_MemRead && bus.IDEX_RegisterRt != RZ;
    genvar i;
    generate
        for (i = 0; i < NREG; i++) begin : g_sb
            sb_entry #(.CNT_W(CNT_W)) u_entry (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (capture && bus.IDEX_RegisterRt == REG_ADDR_W'(i)),
                .dec      (1'b1),
                .hold     (bus.MemStall),
                .load_val (CNT_W'(LOAD_LAT - 1)),
                .busy     (busy[i])
            );
        end
    endgenerate
    // The EX-stage compare covers the cycle before the scoreboard entry is written.
    assign m_rs = bus.IFID_UsesRs && bus.IFID_RegisterRs != RZ &&
                  ((bus.IDEX_MemRead && bus.IFID_RegisterRs == bus.IDEX_RegisterRt) || busy[bus.IFID_RegisterRs]);
    assign m_rt = bus.IFID_UsesRt && bus.IFID_RegisterRt != RZ &&
                  ((bus.IDEX_MemRead && bus.IFID_RegisterRt == bus.IDEX_RegisterRt) || busy[bus.IFID_RegisterRt]);
    assign hazard = m_rs || m_rt;
    always_comb
        ctl = bus.MemStall ? CTL_FREEZE : bus.BranchTaken ? CTL_FLUSH : hazard ? CTL_STALL : CTL_RUN;
    assign bus.PCWrite   = ctl.PCWrite;
    assign bus.IFIDWrite = ctl.IFIDWrite;
    assign bus.OP        = ctl.OP;
    assign bus.IFIDFlush = ctl.IFIDFlush;
`ifdef LOAD_USE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) bus.StallCount <= '0;
        else if (!bus.MemStall && !bus.BranchTaken && hazard && bus.StallCount != '1)
            bus.StallCount <= bus.StallCount + 32'd1;
`endif
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: directed checks of three latencies (1,2,3) driven by one shared stimulus.
module tb_load_use_scoreboard;
    localparam logic [3:0] RUN = 4'b1110, STALL = 4'b0000, FREEZE = 4'b0010, FLUSH = 4'b1101;
    logic clk = 1'b0, rst_n = 1'b0;
    logic mr, urs, urt, br, ms;
    logic [4:0] ex, rs, rt;
    int total = 0, bad = 0, n1, n2, n3;
    load_use_scoreboard_if #(.REG_ADDR_W(5)) b1 ();
    load_use_scoreboard_if #(.REG_ADDR_W(5)) b2 ();
    load_use_scoreboard_if #(.REG_ADDR_W(5)) b3 ();
    load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    load_use_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    always #5 clk = ~clk;
    assign {b1.IDEX_MemRead, b1.IDEX_RegisterRt, b1.IFID_RegisterRs, b1.IFID_UsesRs, b1.IFID_RegisterRt, b1.IFID_UsesRt, b1.BranchTaken, b1.MemStall} = {mr, ex, rs, urs, rt, urt, br, ms};
    assign {b2.IDEX_MemRead, b2.IDEX_RegisterRt, b2.IFID_RegisterRs, b2.IFID_UsesRs, b2.IFID_RegisterRt, b2.IFID_UsesRt, b2.BranchTaken, b2.MemStall} = {mr, ex, rs, urs, rt, urt, br, ms};
    assign {b3.IDEX_MemRead, b3.IDEX_RegisterRt, b3.IFID_RegisterRs, b3.IFID_UsesRs, b3.IFID_RegisterRt, b3.IFID_UsesRt, b3.BranchTaken, b3.MemStall} = {mr, ex, rs, urs, rt, urt, br, ms};
    wire [3:0] o1 = {b1.PCWrite, b1.IFIDWrite, b1.OP, b1.IFIDFlush};
    wire [3:0] o2 = {b2.PCWrite, b2.IFIDWrite, b2.OP, b2.IFIDFlush};
    wire [3:0] o3 = {b3.PCWrite, b3.IFIDWrite, b3.OP, b3.IFIDFlush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [4:0] e, input logic [4:0] s, input logic us,
                         input logic [4:0] t, input logic ut, input logic b, input logic st);
        {mr, ex, rs, urs, rt, urt, br, ms} = {m, e, s, us, t, ut, b, st};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        n1 = 0; n2 = 0; n3 = 0;
    endtask

    task automatic count(input int c);
        for (int k = 0; k < c; k++) begin
            #1;
            if (o1 == STALL) n1++;
            if (o2 == STALL) n2++;
            if (o3 == STALL) n3++;
            step();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_l1", o1, RUN);
        chk("rst_l3", o3, RUN);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_l2", o2, RUN);
        // one-bubble classic behaviour at LOAD_LAT=1
        drive(1, 5, 5, 1, 0, 0, 0, 0);
        #1;
        chk("lu1_stall", o1, STALL);
        chk("lu3_ex_stall", o3, STALL);
        step();
        drive(0, 0, 5, 1, 0, 0, 0, 0);
        #1;
        chk("lu1_resume", o1, RUN);
        chk("lu3_busy", o3, STALL);
        // consumer directly behind the load
        step();
        do_reset();
        drive(1, 7, 0, 0, 7, 1, 0, 0);
        count(1);
        drive(0, 0, 0, 0, 7, 1, 0, 0);
        count(5);
        chk("back_l1", n1, 1);
        chk("back_l2", n2, 2);
        chk("back_l3", n3, 3);
        // one independent instruction in between
        do_reset();
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        count(1);
        drive(0, 0, 0, 0, 7, 1, 0, 0);
        count(5);
        chk("gap_l1", n1, 0);
        chk("gap_l2", n2, 1);
        chk("gap_l3", n3, 2);
        // reloading a busy register restarts the countdown
        do_reset();
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 7, 1, 0, 0);
        count(5);
        chk("reload_l3", n3, 2);
        chk("reload_l2", n2, 1);
        // r0 and unused source never stall
        do_reset();
        drive(1, 0, 0, 1, 0, 1, 0, 0);
        #1;
        chk("r0_ex_l1", o1, RUN);
        chk("r0_ex_l3", o3, RUN);
        step();
        drive(0, 0, 0, 1, 0, 1, 0, 0);
        #1;
        chk("r0_sb_l3", o3, RUN);
        do_reset();
        drive(1, 5, 5, 0, 0, 0, 0, 0);
        #1;
        chk("nouse_ex_l1", o1, RUN);
        chk("nouse_ex_l3", o3, RUN);
        step();
        drive(0, 0, 5, 0, 0, 0, 0, 0);
        #1;
        chk("nouse_sb_l3", o3, RUN);
        // flush beats hazard and leaves the scoreboard intact
        do_reset();
        drive(1, 4, 4, 1, 0, 0, 1, 0);
        #1;
        chk("flush_l2", o2, FLUSH);
        chk("flush_l1", o1, FLUSH);
        step();
        drive(0, 0, 4, 1, 0, 0, 0, 0);
        #1;
        chk("flush_keep_l2", o2, STALL);
        chk("flush_keep_l1", o1, RUN);
        // MemStall mid-countdown freezes outputs and counters
        do_reset();
        drive(1, 6, 0, 0, 6, 1, 0, 0);
        count(1);
        drive(0, 0, 0, 0, 6, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("freeze%0d_l2", k), o2, FREEZE);
            step();
        end
        drive(0, 0, 0, 0, 6, 1, 0, 0);
        count(5);
        chk("ms_l1", n1, 1);
        chk("ms_l2", n2, 2);
        chk("ms_l3", n3, 3);
        // asynchronous reset while r9 is busy
        do_reset();
        drive(1, 9, 9, 1, 0, 0, 0, 0);
        step();
        drive(0, 0, 9, 1, 0, 0, 0, 0);
        #1;
        chk("r9_busy_l3", o3, STALL);
        rst_n = 1'b0;
        #1;
        chk("r9_async_clr_l3", o3, RUN);
        drive(1, 9, 9, 1, 0, 0, 0, 0);
        #1;
        chk("r9_rst_ex_l3", o3, STALL);
        drive(0, 0, 9, 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("r9_release_l3", o3, RUN);
        step();
        chk("r9_after_l3", o3, RUN);
`ifdef LOAD_USE_STALL_CNT_EN
        do_reset();
        #1;
        chk("cnt_rst", b2.StallCount, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 3, 3, 1, 0, 0, 0, 0);
            step();
            drive(0, 0, 3, 1, 0, 0, 0, 0);
            step();
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 3, 3, 1, 0, 0, 1, 0);
        step();
        drive(0, 0, 3, 1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("cnt_l2", b2.StallCount, 6);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
